// File: rtl/floppy_reg_bank_if.sv
// floppy_reg_bank_if: byte register bus between a host (master) and the register bank (slave)
//   reg_addr     register address
//   write        1 = write, 0 = read; qualified by new_req
//   new_req      one-cycle request strobe
//   write_value  write data
//   read_value   registered read data
//   read_valid   one-cycle pulse one cycle after a read request
interface floppy_reg_bank_if;
   logic [5:0] reg_addr;
   logic       write;
   logic       new_req;
   logic [7:0] write_value;
   logic [7:0] read_value;
   logic       read_valid;
   modport master (output reg_addr, write, new_req, write_value, input read_value, read_valid);
   modport slave (input reg_addr, write, new_req, write_value, output read_value, read_valid);
endinterface

// File: rtl/floppy_reg_bank.sv
// floppy_reg_bank: note registers with mute, all-off, per-channel auto-off timeout and status
//   clk, rst   system clock, asynchronous active-high reset
//   bus        byte register interface (slave side)
//   ch_note    channel i note at [7i+6:7i]
//   ch_en      channel enables after mute
//   led        {zero-pad, ch_en}
module floppy_reg_bank #(
   parameter int NUM_CH  = 6,
   parameter int PRESC_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   floppy_reg_bank_if.slave      bus,
   output logic [7*NUM_CH-1:0]   ch_note,
   output logic [NUM_CH-1:0]     ch_en,
   output logic [7:0]            led
);
   logic [7:0]         note_q [NUM_CH];
   logic [7:0]         cnt [NUM_CH];
   logic [1:0]         ctrl;
   logic [7:0]         timeout;
   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic               wr;
   logic               rd;
   logic [7:0]         status;
   logic [7:0]         rdata;
   assign tick = &presc;
   assign wr   = bus.new_req & bus.write;
   assign rd   = bus.new_req & ~bus.write;
   always_comb begin
      status  = '0;
      rdata   = '0;
      ch_note = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         status[i]          = note_q[i][7];
         ch_note[7*i +: 7]  = note_q[i][6:0];
         if (bus.reg_addr == 6'(i)) rdata = note_q[i];
      end
      rdata = bus.reg_addr == 6'h20 ? {6'b0, ctrl} :
              bus.reg_addr == 6'h21 ? timeout :
              bus.reg_addr == 6'h22 ? status : rdata;
   end
   assign ch_en = status[NUM_CH-1:0] & {NUM_CH{~ctrl[0]}};
   assign led   = 8'(ch_en);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc          <= '0;
         ctrl           <= '0;
         timeout        <= '0;
         bus.read_value <= '0;
         bus.read_valid <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            note_q[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         presc          <= presc + 1'b1;
         bus.read_valid <= rd;
         if (rd) bus.read_value <= rdata;
         if (wr && bus.reg_addr == 6'h20) ctrl <= bus.write_value[1:0];
         if (wr && bus.reg_addr == 6'h21) timeout <= bus.write_value;
         for (int i = 0; i < NUM_CH; i++) begin
            // a direct write beats a same-cycle expiry and restarts the countdown
            if (wr && bus.reg_addr == 6'(i)) begin
               note_q[i] <= bus.write_value;
               cnt[i]    <= bus.write_value[7] ? timeout : 8'd0;
            end else begin
               if (tick && cnt[i] != 8'd0) cnt[i] <= cnt[i] - 1'b1;
               if ((tick && cnt[i] == 8'd1 && ctrl[1]) || (wr && bus.reg_addr == 6'h23))
                  note_q[i][7] <= 1'b0;
            end
         end
      end
   end
endmodule
